// File: rtl/cp0_except_unit_pkg.sv
`default_nettype none
//============================================================================
// Module : cp0_except_unit_pkg
// Brief  : CP0 register numbers, exception codes and field layout
// Rev    : 1.0  initial release
//============================================================================
package cp0_except_unit_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [7:0] {
        EXC_NONE = 8'h00,
        EXC_INT  = 8'h01,
        EXC_ADEL = 8'h04,
        EXC_ADES = 8'h05,
        EXC_SYS  = 8'h08,
        EXC_BP   = 8'h09,
        EXC_RI   = 8'h0A,
        EXC_OV   = 8'h0C,
        EXC_ERET = 8'h0E
    } exc_code_e;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LO   = 8;
    localparam int STATUS_BEV_BIT = 22;
    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_IP_LO    = 8;
    localparam int CAUSE_TI_BIT   = 30;
    localparam int CAUSE_BD_BIT   = 31;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_WMASK       = 32'h0000_FF03;

    // Interrupts report ExcCode 0 even though the external code is 01.
    function automatic logic [4:0] exccode_field(input exc_code_e code);
        return (code == EXC_INT) ? 5'd0 : code[4:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
//============================================================================
// Module : cp0_timer
// Brief  : CP0 Count register with prescaler and Compare-match interrupt TI
// Rev    : 1.0  initial release
//============================================================================
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_compare,
    output logic [31:0] o_count,
    output logic        o_ti
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_count;
    logic             r_ti;
    logic             w_tick;
    logic [31:0]      w_count_next;

    assign w_tick       = (r_div == DIV_LAST);
    assign w_count_next = r_count + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= '0;
            r_count <= '0;
            r_ti    <= 1'b0;
        end else begin
            if (i_count_we) begin
                r_count <= i_wdata;
                r_div   <= '0;
            end else if (w_tick) begin
                r_count <= w_count_next;
                r_div   <= '0;
            end else begin
                r_div   <= r_div + DIV_W'(1);
            end
            // A Compare write always wins over a coincident match.
            if (i_compare_we)
                r_ti <= 1'b0;
            else if (!i_count_we && w_tick && (w_count_next == i_compare))
                r_ti <= 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_ti    = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_except_unit.sv
`default_nettype none
//============================================================================
// Module : cp0_except_unit
// Brief  : M-stage exception prioritiser, redirect logic and CP0 registers
// Rev    : 1.0  initial release
//============================================================================
module cp0_except_unit
    import cp0_except_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic [31:0] pcM,
    input  logic        is_in_delayslotM,
    input  logic        pc_adelM,
    input  logic        invalidM,
    input  logic        syscallM,
    input  logic        breakM,
    input  logic        eretM,
    input  logic        overflowM,
    input  logic        mem_adelM,
    input  logic        mem_adesM,
    input  logic [31:0] bad_mem_addrM,
    input  logic        cp0writeM,
    input  logic [4:0]  waddrM,
    input  logic [31:0] wdataM,
    input  logic [4:0]  raddrE,
    output logic [31:0] rdataE,
    output logic [7:0]  excepttypeM,
    output logic        flush_except,
    output logic [31:0] newpcM,
    output logic [31:0] epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o
);

    logic [31:0] r_badvaddr;
    logic [31:0] r_compare;
    logic [31:0] r_epc;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exc;

    logic [31:0] w_count;
    logic        w_ti;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic        w_int_pending;
    exc_code_e   w_code;
    logic        w_take;
    logic        w_wr;
    logic        w_fwd;
    logic [31:0] w_rdata;

    assign w_status = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign w_cause  = {r_cause_bd, w_ti, 14'd0, r_cause_ip_hw, r_cause_ip_sw,
                       1'b0, r_cause_exc, 2'b00};

    assign w_int_pending = r_status_ie & ~r_status_exl &
                           (|(w_cause[CAUSE_IP_LO +: 8] & r_status_im));

    always_comb begin
        w_code = EXC_NONE;
        if (rst && (pcM != 32'd0)) begin
            if (w_int_pending)  w_code = EXC_INT;
            else if (pc_adelM)  w_code = EXC_ADEL;
            else if (invalidM)  w_code = EXC_RI;
            else if (overflowM) w_code = EXC_OV;
            else if (syscallM)  w_code = EXC_SYS;
            else if (breakM)    w_code = EXC_BP;
            else if (mem_adelM) w_code = EXC_ADEL;
            else if (mem_adesM) w_code = EXC_ADES;
            else if (eretM)     w_code = EXC_ERET;
        end
    end

    assign excepttypeM  = w_code;
    assign flush_except = |excepttypeM;
    assign newpcM       = !rst ? 32'd0 : ((w_code == EXC_ERET) ? r_epc : EXC_VECTOR);

    assign w_take = (w_code != EXC_NONE) && (w_code != EXC_ERET);
    // Any encoded event squashes the MTC0 carried by the same instruction.
    assign w_wr   = cp0writeM && (w_code == EXC_NONE);

    cp0_timer #(
        .COUNT_DIV    (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_count_we   (w_wr && (waddrM == CP0_COUNT)),
        .i_compare_we (w_wr && (waddrM == CP0_COMPARE)),
        .i_wdata      (wdataM),
        .i_compare    (r_compare),
        .o_count      (w_count),
        .o_ti         (w_ti)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_badvaddr    <= '0;
            r_compare     <= '0;
            r_epc         <= '0;
            r_status_im   <= '0;
            r_status_exl  <= 1'b0;
            r_status_ie   <= 1'b0;
            r_cause_bd    <= 1'b0;
            r_cause_ip_hw <= '0;
            r_cause_ip_sw <= '0;
            r_cause_exc   <= '0;
        end else begin
            r_cause_ip_hw <= {int_i[5] | w_ti, int_i[4:0]};
            if (w_take) begin
                r_status_exl <= 1'b1;
                r_cause_exc  <= exccode_field(w_code);
                // Nested faults inside a handler keep the original return point.
                if (!r_status_exl) begin
                    r_epc      <= is_in_delayslotM ? (pcM - 32'd4) : pcM;
                    r_cause_bd <= is_in_delayslotM;
                end
                if (w_code == EXC_ADEL)
                    r_badvaddr <= pc_adelM ? pcM : bad_mem_addrM;
                else if (w_code == EXC_ADES)
                    r_badvaddr <= bad_mem_addrM;
            end else if (w_code == EXC_ERET) begin
                r_status_exl <= 1'b0;
            end
            if (w_wr) begin
                case (waddrM)
                    CP0_STATUS: begin
                        r_status_im  <= wdataM[STATUS_IM_LO +: 8];
                        r_status_exl <= wdataM[STATUS_EXL_BIT];
                        r_status_ie  <= wdataM[STATUS_IE_BIT];
                    end
                    CP0_CAUSE:   r_cause_ip_sw <= wdataM[CAUSE_IP_LO +: 2];
                    CP0_COMPARE: r_compare     <= wdataM;
                    CP0_EPC:     r_epc         <= wdataM;
                    default: ;
                endcase
            end
        end
    end

    assign w_fwd = w_wr && (waddrM == raddrE);

    always_comb begin
        w_rdata = 32'd0;
        case (raddrE)
            CP0_BADVADDR: w_rdata = r_badvaddr;
            CP0_COUNT:    w_rdata = w_fwd ? wdataM : w_count;
            CP0_COMPARE:  w_rdata = w_fwd ? wdataM : r_compare;
            CP0_STATUS:   w_rdata = w_fwd ? ((w_status & ~STATUS_WMASK) | (wdataM & STATUS_WMASK))
                                          : w_status;
            CP0_CAUSE:    w_rdata = w_fwd ? {w_cause[31:10], wdataM[9:8], w_cause[7:0]}
                                          : w_cause;
            CP0_EPC:      w_rdata = w_fwd ? wdataM : r_epc;
            default:      w_rdata = 32'd0;
        endcase
    end

    assign rdataE   = rst ? w_rdata : 32'd0;
    assign epc_o    = r_epc;
    assign status_o = w_status;
    assign cause_o  = w_cause;

endmodule
`default_nettype wire

// File: tb/tb_cp0_except_unit.sv
`default_nettype none
//============================================================================
// Module : tb_cp0_except_unit
// Brief  : directed + random bench for cp0_except_unit against a word-level model
// Rev    : 1.0  initial release
//============================================================================
module tb_cp0_except_unit;

    localparam int          COUNT_DIV = 2;
    localparam logic [31:0] VEC       = 32'hBFC0_0380;
    localparam logic [31:0] SMASK     = 32'h0000_FF03;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  int_i;
    logic [31:0] pcM;
    logic        is_in_delayslotM, pc_adelM, invalidM, syscallM, breakM, eretM;
    logic        overflowM, mem_adelM, mem_adesM, cp0writeM;
    logic [31:0] bad_mem_addrM, wdataM;
    logic [4:0]  waddrM, raddrE;
    logic [31:0] rdataE, newpcM, epc_o, status_o, cause_o;
    logic [7:0]  excepttypeM;
    logic        flush_except;

    cp0_except_unit #(.EXC_VECTOR(VEC), .COUNT_DIV(COUNT_DIV)) dut (
        .clk(clk), .rst(rst), .int_i(int_i), .pcM(pcM),
        .is_in_delayslotM(is_in_delayslotM), .pc_adelM(pc_adelM),
        .invalidM(invalidM), .syscallM(syscallM), .breakM(breakM),
        .eretM(eretM), .overflowM(overflowM), .mem_adelM(mem_adelM),
        .mem_adesM(mem_adesM), .bad_mem_addrM(bad_mem_addrM),
        .cp0writeM(cp0writeM), .waddrM(waddrM), .wdataM(wdataM),
        .raddrE(raddrE), .rdataE(rdataE), .excepttypeM(excepttypeM),
        .flush_except(flush_except), .newpcM(newpcM), .epc_o(epc_o),
        .status_o(status_o), .cause_o(cause_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Architectural model: whole 32-bit register words plus timer phase.
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    int          m_phase;
    logic        m_ti;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_status = 32'h0040_0000;
        m_cause = '0; m_epc = '0; m_badv = '0; m_count = '0; m_compare = '0;
        m_phase = 0; m_ti = 1'b0;
    endtask

    function automatic logic [31:0] cause_word();
        return {m_cause[31], m_ti, m_cause[29:0]};
    endfunction

    function automatic logic [7:0] exp_code();
        if (pcM == 32'd0) return 8'h00;
        if (m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0)) return 8'h01;
        if (pc_adelM)  return 8'h04;
        if (invalidM)  return 8'h0A;
        if (overflowM) return 8'h0C;
        if (syscallM)  return 8'h08;
        if (breakM)    return 8'h09;
        if (mem_adelM) return 8'h04;
        if (mem_adesM) return 8'h05;
        if (eretM)     return 8'h0E;
        return 8'h00;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [7:0] code);
        logic        f;
        logic [31:0] v;
        f = cp0writeM && (code == 8'h00) && (waddrM == raddrE);
        case (raddrE)
            5'd8:  v = m_badv;
            5'd9:  v = f ? wdataM : m_count;
            5'd11: v = f ? wdataM : m_compare;
            5'd12: v = f ? ((m_status & ~SMASK) | (wdataM & SMASK)) : m_status;
            5'd13: begin v = cause_word(); if (f) v[9:8] = wdataM[9:8]; end
            5'd14: v = f ? wdataM : m_epc;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_update(input logic [7:0] code);
        logic wr, take, old_exl, old_ti, ti_set;
        wr      = cp0writeM && (code == 8'h00);
        take    = (code != 8'h00) && (code != 8'h0E);
        old_exl = m_status[1];
        old_ti  = m_ti;
        ti_set  = 1'b0;
        if (wr && waddrM == 5'd9) begin
            m_count = wdataM; m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == COUNT_DIV) begin
                m_phase = 0; m_count = m_count + 32'd1;
                if (m_count == m_compare) ti_set = 1'b1;
            end
        end
        if (wr && waddrM == 5'd11) begin m_compare = wdataM; m_ti = 1'b0; end
        else if (ti_set) m_ti = 1'b1;
        m_cause[15:10] = {int_i[5] | old_ti, int_i[4:0]};
        if (take) begin
            if (!old_exl) begin
                m_epc = is_in_delayslotM ? pcM - 32'd4 : pcM;
                m_cause[31] = is_in_delayslotM;
            end
            m_cause[6:2] = (code == 8'h01) ? 5'd0 : code[4:0];
            m_status[1] = 1'b1;
            if (code == 8'h04 && pc_adelM) m_badv = pcM;
            else if (code == 8'h04 || code == 8'h05) m_badv = bad_mem_addrM;
        end else if (code == 8'h0E) begin
            m_status[1] = 1'b0;
        end
        if (wr) begin
            case (waddrM)
                5'd12: m_status = (m_status & ~SMASK) | (wdataM & SMASK);
                5'd13: m_cause[9:8] = wdataM[9:8];
                5'd14: m_epc = wdataM;
                default: ;
            endcase
        end
    endtask

    // One cycle: compare every output at the falling edge, advance model at the rising edge.
    task automatic step();
        logic [7:0] code;
        @(negedge clk);
        code = exp_code();
        chk("excepttypeM", {24'd0, excepttypeM}, {24'd0, code});
        chk("flush_except", {31'd0, flush_except}, {31'd0, (code != 8'h00)});
        chk("newpcM", newpcM, (code == 8'h0E) ? m_epc : VEC);
        chk("rdataE", rdataE, exp_rdata(code));
        chk("epc_o", epc_o, m_epc);
        chk("status_o", status_o, m_status);
        chk("cause_o", cause_o, cause_word());
        @(posedge clk);
        model_update(code);
        #1;
    endtask

    task automatic idle();
        int_i = '0; pcM = '0; is_in_delayslotM = 0; pc_adelM = 0; invalidM = 0;
        syscallM = 0; breakM = 0; eretM = 0; overflowM = 0; mem_adelM = 0;
        mem_adesM = 0; bad_mem_addrM = '0; cp0writeM = 0; waddrM = '0; wdataM = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); cp0writeM = 1; waddrM = a; wdataM = d; step(); idle();
    endtask

    task automatic eret_at(input logic [31:0] pc);
        idle(); pcM = pc; eretM = 1; step(); idle();
    endtask

    initial begin
        logic [4:0] regs [6];
        regs = '{5'd8, 5'd9, 5'd11, 5'd13, 5'd14, 5'd3};
        idle(); raddrE = 5'd12;
        model_reset();
        #1;
        chk("rst_rdata", rdataE, 32'h0);
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_newpc", newpcM, 32'h0);
        chk("rst_code", {24'd0, excepttypeM}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("read12", rdataE, 32'h0040_0000);
        for (int i = 0; i < 5; i++) begin
            raddrE = regs[i]; #1;
            chk("read_zero", rdataE, 32'h0);
        end
        chk("idle_code", {24'd0, excepttypeM}, 32'h0);
        step();

        raddrE = 5'd13;
        pcM = 32'hBFC0_0100; syscallM = 1; #1;
        chk("sys_code", {24'd0, excepttypeM}, 32'h08);
        chk("sys_flush", {31'd0, flush_except}, 32'h1);
        chk("sys_newpc", newpcM, 32'hBFC0_0380);
        step(); idle(); #1;
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_exc", {27'd0, cause_o[6:2]}, 32'd8);
        chk("sys_exl", {31'd0, status_o[1]}, 32'h1);

        pcM = 32'hBFC0_0104; eretM = 1; #1;
        chk("eret1_newpc", newpcM, 32'hBFC0_0100);
        step(); idle();
        pcM = 32'hBFC0_0204; overflowM = 1; is_in_delayslotM = 1; #1;
        chk("ov_code", {24'd0, excepttypeM}, 32'h0C);
        step(); idle(); #1;
        chk("ov_epc", epc_o, 32'hBFC0_0200);
        chk("ov_bd", {31'd0, cause_o[31]}, 32'h1);
        pcM = 32'hBFC0_0300; overflowM = 1; step(); idle(); #1;
        chk("ov2_epc", epc_o, 32'hBFC0_0200);

        eret_at(32'hBFC0_0304);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        repeat (20) step();
        chk("timer_ti", {31'd0, cause_o[30]}, 32'h1);
        step();
        chk("timer_ip7", {31'd0, cause_o[15]}, 32'h1);
        pcM = 32'hBFC0_0400; #1;
        chk("int_code", {24'd0, excepttypeM}, 32'h01);
        step(); idle();
        mtc0(5'd11, 32'h100);
        chk("ti_clear", {31'd0, cause_o[30]}, 32'h0);

        eret_at(32'hBFC0_0404);
        mtc0(5'd12, 32'h0);
        pcM = 32'hBFC0_0500; invalidM = 1; syscallM = 1; mem_adelM = 1;
        cp0writeM = 1; waddrM = 5'd14; wdataM = 32'hDEAD_BEEF; raddrE = 5'd14; #1;
        chk("ri_code", {24'd0, excepttypeM}, 32'h0A);
        step(); idle(); #1;
        chk("ri_epc", epc_o, 32'hBFC0_0500);
        pcM = 32'hBFC0_0504; eretM = 1; #1;
        chk("eret_newpc", newpcM, 32'hBFC0_0500);
        step(); idle(); #1;
        chk("eret_exl", {31'd0, status_o[1]}, 32'h0);

        for (int c = 0; c < 2500; c++) begin
            int_i            = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
            pcM              = ($urandom_range(0, 3) == 0) ? 32'd0 : {$urandom() >> 2, 2'b00};
            is_in_delayslotM = ($urandom_range(0, 3) == 0);
            pc_adelM         = ($urandom_range(0, 15) == 0);
            invalidM         = ($urandom_range(0, 15) == 0);
            syscallM         = ($urandom_range(0, 15) == 0);
            breakM           = ($urandom_range(0, 15) == 0);
            eretM            = ($urandom_range(0, 7) == 0);
            overflowM        = ($urandom_range(0, 15) == 0);
            mem_adelM        = ($urandom_range(0, 15) == 0);
            mem_adesM        = ($urandom_range(0, 15) == 0);
            bad_mem_addrM    = $urandom();
            cp0writeM        = ($urandom_range(0, 3) == 0);
            waddrM           = regs[$urandom_range(0, 5)];
            if (waddrM == 5'd3) waddrM = 5'd12;
            wdataM           = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 40));
            raddrE           = ($urandom_range(0, 5) == 0) ? 5'd12 : regs[$urandom_range(0, 5)];
            step();
        end

        idle();
        mtc0(5'd12, 32'h0);
        mtc0(5'd9, 32'h1234);
        pcM = 32'hBFC0_0600; syscallM = 1; step(); idle();
        @(negedge clk); #2;
        rst = 1'b0; raddrE = 5'd12; #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_epc", epc_o, 32'h0);
        chk("arst_cause", cause_o, 32'h0);
        chk("arst_rdata", rdataE, 32'h0);
        chk("arst_newpc", newpcM, 32'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; raddrE = 5'd9; #1;
        chk("arst_count", rdataE, 32'h0);
        step();
        raddrE = 5'd12; step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_except_unit.md
Name: cp0_except_unit

Overview:
- M-stage exception encoder plus CP0 register file for the 5-stage MIPS core.
- Takes the per-instruction fault flags raised upstream (decoder `invalid`, ALU overflow, address checks, SYSCALL/BREAK/ERET) and hardware interrupts.
- Produces the prioritised `excepttypeM` that the main decoder's pipeline control registers consume as a flush, together with the redirect PC.
- Owns BadVAddr, Count, Compare, Status, Cause and EPC, and services MFC0/MTC0.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for all non-ERET exceptions.
- COUNT_DIV, 2, clock cycles per Count increment.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- int_i  in  6  hardware interrupt lines, level
- pcM  in  32  M-stage PC; 0 means bubble
- is_in_delayslotM  in  1  M instruction sits in a branch delay slot
- pc_adelM  in  1  fetch address misaligned
- invalidM  in  1  reserved instruction (decoder `invalid`, piped)
- syscallM, breakM, eretM, overflowM  in  1 each  instruction events
- mem_adelM, mem_adesM  in  1 each  data load/store address error
- bad_mem_addrM  in  32  faulting data address
- cp0writeM  in  1  MTC0 commit
- waddrM  in  5  MTC0 register number
- wdataM  in  32  MTC0 data
- raddrE  in  5  MFC0 register number
- rdataE  out  32  MFC0 data
- excepttypeM  out  8  exception code; 0 = none
- flush_except  out  1  flush all stages
- newpcM  out  32  redirect PC
- epc_o, status_o, cause_o  out  32 each  debug/visibility

Behaviour:
- Reset (rst=0, async):
  - Status = 32'h0040_0000 (BEV=1); all other registers 0.
  - Divider and TI cleared.
  - excepttypeM=0, flush_except=0, newpcM=0, rdataE=0.
- Codes (8-bit):
  - 01 interrupt
  - 04 AdEL
  - 05 AdES
  - 08 Sys
  - 09 Bp
  - 0A RI
  - 0C Ov
  - 0E ERET
- Priority, highest first; only the highest event is encoded:
  1. interrupt
  2. pc_adel
  3. RI
  4. Ov
  5. Sys
  6. Bp
  7. mem_adel
  8. mem_ades
  9. ERET
- Interrupt taken only when all hold: pcM != 0, Status.IE=1, Status.EXL=0, and |(Cause.IP[7:0] & Status.IM[7:0]).
- All events are ignored when pcM == 0.
- excepttypeM, flush_except and newpcM are combinational in the same cycle.
  - flush_except = |excepttypeM.
  - newpcM = EPC for code 0E, else EXC_VECTOR.
- Non-ERET exception, state update on the next edge:
  - If EXL was 0: EPC <= delayslot ? pcM-4 : pcM; Cause.BD <= delayslot.
  - Cause.ExcCode[6:2] <= code[4:0] (interrupt → 0); Status.EXL <= 1.
  - BadVAddr <= pcM for pc_adel; BadVAddr <= bad_mem_addrM for mem_adel/ades; otherwise unchanged.
- ERET: Status.EXL <= 0; no other state changes.
- MTC0 is suppressed when excepttypeM != 0 in the same cycle (the instruction is squashed).
- Write masks:
  - Status: IM[15:8], EXL[1] and IE[0] writable.
  - Cause: only IP[9:8] writable.
  - Count, Compare, EPC: fully writable.
  - BadVAddr: read-only.
  - Unimplemented numbers ignore writes.
- Cause.IP[7:2] is resampled every cycle as {int_i[5] | TI, int_i[4:0]}.
- Timer:
  - Count increments by 1 every COUNT_DIV cycles and wraps 0xFFFFFFFF → 0.
  - An MTC0 to Count loads wdataM and resets the divider phase.
  - TI (Cause[30]) sets on the increment where the new Count == Compare.
  - An MTC0 to Compare clears TI. If set and clear coincide, clear wins.
- Read path: rdataE is combinational from raddrE.
  - If cp0writeM is active for the same register and not suppressed, wdataM is forwarded with its write mask applied.
  - Unimplemented registers read 0.

Decomposition:
- Shared defines.vh gains:
  - CP0 register numbers 8/9/11/12/13/14
  - exception code constants
  - Status/Cause bit positions
  - EXC_VECTOR default
- One sub-module: cp0_timer. It holds Count, the divider and TI, and takes the Count/Compare write strobes and the Compare value.

Test Plan:
- Release reset → read 12 = 32'h00400000; reads of 8/9/11/13/14 = 0; excepttypeM=0 with all inputs idle.
- syscallM=1, pcM=BFC00100, delayslot 0 → excepttypeM=08, flush=1, newpcM=BFC00380; next cycle EPC=BFC00100, Cause[6:2]=8, Status.EXL=1.
- overflowM=1, pcM=BFC00204, delayslot 1 → code 0C; EPC=BFC00200, Cause.BD=1. A second Ov while EXL=1 → EPC unchanged.
- Timer interrupt, COUNT_DIV=2:
  - Setup: MTC0 Status=0x00008001, Compare=10, Count=0.
  - After 20 cycles TI=1 and Cause.IP7=1; next non-bubble pcM → code 01.
  - MTC0 Compare clears TI.
- invalidM+syscallM+mem_adelM together with cp0writeM to EPC → code 0A; EPC gets pcM, not wdataM. Then eretM → newpcM=EPC, EXL=0.
- Assert rst mid-count, with Count=0x1234 and EXL=1 → all registers return to reset values immediately, without waiting for a clock edge.
